// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write/status bundle for the program loader.
interface imem_loader_if #(parameter int ADDR_W = 5);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    modport master (output in_valid, in_data, input in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
    modport slave  (input in_valid, in_data, output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a header/data/checksum byte stream, holding the core until a verified image is loaded.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;
    localparam logic [7:0] MAX_N = 8'(DEPTH);
    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d, sum_q, sum_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d, wr_addr_q, wr_addr_d;
    logic [31:0]       word_q, word_d, wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              take;
    assign take         = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !rst && state_q != WRITE;
    assign bus.wr_en    = wr_en_q && !rst;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = rst || state_q != DONE;
    assign bus.done     = !rst && state_q == DONE;
    assign bus.error    = !rst && state_q == ERR;
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        sum_d     = sum_q;
        bcnt_d    = bcnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE, ERR: if (take) begin
                if (bus.in_data == 8'd0 || bus.in_data > MAX_N) begin
                    state_d = ERR;
                end else begin
                    state_d = LOAD;
                    n_d     = bus.in_data;
                    bcnt_d  = 2'd0;
                    idx_d   = '0;
                    sum_d   = 8'd0;
                end
            end
            LOAD: if (take) begin
                // bytes arrive LSB first, so shift in from the top
                word_d = {bus.in_data, word_q[31:8]};
                sum_d  = sum_q + bus.in_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = {bus.in_data, word_q[31:8]};
                end
            end
            WRITE: begin
                if (8'(idx_q) + 8'd1 == n_q) begin
                    state_d = CHECK;
                end else begin
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                    bcnt_d  = 2'd0;
                end
            end
            CHECK: if (take) state_d = (bus.in_data == sum_q) ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= 8'd0;
            sum_q     <= 8'd0;
            bcnt_q    <= 2'd0;
            idx_q     <= '0;
            word_q    <= 32'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            sum_q     <= sum_d;
            bcnt_q    <= bcnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test-plan loads plus randomized streams checked cycle by cycle against a stream-level model.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(5)) bus();
    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int nlow = 0;
    logic [36:0] wlog[$];

    // Stream-level model: position within the current image, expected status and pending write.
    bit m_load, m_done, m_err, m_stall, m_any, acc;
    int m_n, m_cnt, m_waddr;
    logic [7:0] m_sum;
    logic [7:0] m_bytes[4];
    logic [31:0] m_wdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && !m_stall));
        chk("wr_en", 32'(bus.wr_en), 32'(m_stall && !rst));
        if (m_stall || !m_any) begin
            chk("wr_addr", 32'(bus.wr_addr), m_any ? m_waddr : 0);
            chk("wr_data", bus.wr_data, m_any ? m_wdata : 32'd0);
        end
        chk("cpu_hold", 32'(bus.cpu_hold), 32'(rst || !m_done));
        chk("done", 32'(bus.done), 32'(m_done && !rst));
        chk("error", 32'(bus.error), 32'(m_err && !rst));
        if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
        if (!rst && !bus.in_ready) nlow++;
    end

    task automatic model_byte(logic [7:0] b);
        if (!m_load) begin
            if (b == 0 || b > 32) begin m_err = 1; m_done = 0; end
            else begin m_load = 1; m_n = b; m_cnt = 0; m_sum = 0; m_err = 0; m_done = 0; end
        end else if (m_cnt < 4 * m_n) begin
            m_bytes[m_cnt % 4] = b;
            m_sum += b;
            m_cnt++;
            if (m_cnt % 4 == 0) begin
                m_stall = 1;
                m_any   = 1;
                m_waddr = m_cnt / 4 - 1;
                m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            end
        end else begin
            m_load = 0;
            m_done = (b == m_sum);
            m_err  = !m_done;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        acc = 0;
        if (rst) begin
            m_load = 0; m_done = 0; m_err = 0; m_stall = 0; m_any = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            acc = bus.in_valid && !m_stall;
            m_stall = 0;
            if (acc) model_byte(bus.in_data);
        end
        #1;
    endtask

    task automatic send(logic [7:0] b, int gap);
        repeat (gap) begin bus.in_valid = 0; bus.in_data = 8'($urandom); tick(); end
        bus.in_valid = 1;
        bus.in_data  = b;
        for (int i = 0; i < 8; i++) begin tick(); if (acc) break; end
        chk("accept", 32'(acc), 32'd1);
        bus.in_valid = 0;
    endtask

    task automatic pulse_rst();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic wchk(int i, int addr, logic [31:0] data);
        if (i < wlog.size()) begin
            chk("wlog_addr", 32'(wlog[i][36:32]), addr);
            chk("wlog_data", wlog[i][31:0], data);
        end else chk("wlog_present", 32'(wlog.size()), i + 1);
    endtask

    // cut < 0 means no reset; otherwise reset after cut data bytes
    task automatic load_rand(int n, bit bad, int gmax, int cut);
        logic [7:0] s, b;
        s = 0;
        send(8'(n), $urandom_range(0, gmax));
        for (int i = 0; i < 4 * n; i++) begin
            if (i == cut) begin pulse_rst(); return; end
            b = 8'($urandom);
            s += b;
            send(b, $urandom_range(0, gmax));
        end
        send(bad ? s ^ 8'(1 + $urandom_range(0, 254)) : s, $urandom_range(0, gmax));
    endtask

    logic [7:0] good2[9] = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00};

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0;
        bus.in_data  = 0;
        tick();
        chk_en = 1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_hold", 32'(bus.cpu_hold), 1);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        rst = 0;
        tick();
        chk("post_rst_ready", 32'(bus.in_ready), 1);

        wlog.delete();
        foreach (good2[i]) send(good2[i], 0);
        chk("model_sum", 32'(m_sum), 32'hBA);
        send(8'hBA, 0);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_hold", 32'(bus.cpu_hold), 0);
        chk("t1_writes", 32'(wlog.size()), 2);
        wchk(0, 0, 32'h00500113);
        wchk(1, 1, 32'h00210233);

        wlog.delete();
        foreach (good2[i]) send(good2[i], 1);
        send(8'hBB, 0);
        chk("t2_error", 32'(bus.error), 1);
        chk("t2_hold", 32'(bus.cpu_hold), 1);
        chk("t2_done", 32'(bus.done), 0);
        chk("t2_writes", 32'(wlog.size()), 2);

        wlog.delete();
        send(8'h00, 0);
        chk("t3_err0", 32'(bus.error), 1);
        send(8'h21, 0);
        chk("t3_err33", 32'(bus.error), 1);
        tick();
        chk("t3_no_write", 32'(wlog.size()), 0);
        send(8'h01, 0); send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0); send(8'h14, 0);
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_error", 32'(bus.error), 0);
        wchk(0, 0, 32'h12345678);

        wlog.delete();
        nlow = 0;
        load_rand(3, 0, 0, -1);
        chk("t4_stalls", 32'(nlow), 3);
        chk("t4_writes", 32'(wlog.size()), 3);
        for (int i = 0; i < 3; i++) if (i < wlog.size()) chk("t4_addr", 32'(wlog[i][36:32]), i);
        chk("t4_done", 32'(bus.done), 1);

        wlog.delete();
        for (int i = 0; i < 6; i++) send(good2[i], 0);
        pulse_rst();
        repeat (4) tick();
        chk("t5_writes", 32'(wlog.size()), 1);
        chk("t5_hold", 32'(bus.cpu_hold), 1);
        chk("t5_addr", 32'(bus.wr_addr), 0);
        chk("t5_ready", 32'(bus.in_ready), 1);
        wlog.delete();
        foreach (good2[i]) send(good2[i], 0);
        send(8'hBA, 0);
        wchk(0, 0, 32'h00500113);
        chk("t5_done", 32'(bus.done), 1);

        send(8'h01, 0);
        chk("t6_hold", 32'(bus.cpu_hold), 1);
        chk("t6_done", 32'(bus.done), 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0); send(8'h38, 0);
        chk("t6_done2", 32'(bus.done), 1);

        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) send(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(33, 255)), $urandom_range(0, 2));
            else begin
                int n;
                n = $urandom_range(1, 32);
                load_rand(n, $urandom_range(0, 4) == 0, $urandom_range(0, 2),
                          (r == 1) ? $urandom_range(0, 4 * n - 1) : -1);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory from a byte stream before the core runs. It is the write side of the instruction-memory interface that the fetch stage reads from. While loading, it holds the core in reset. It releases the core only after a complete, checksum-verified image has been written.

## Interface
Parameters:
- DEPTH, 32: instruction-memory depth in 32-bit words; legal word counts are 1..DEPTH.
- ADDR_W, 5: word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle; a byte transfers when in_valid && in_ready at a rising edge.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address being written.
- wr_data  output  32  instruction word being written.
- cpu_hold  output  1  holds the core in reset while high.
- done  output  1  a valid image has been loaded; the core is running.
- error  output  1  the last load was rejected.

## Operation
Stream format:
- 1 header byte N, the word count.
- Then 4*N data bytes, little-endian per word: the first byte is bits [7:0], the fourth byte is bits [31:24].
- Then 1 checksum byte, equal to the sum mod 256 of the 4*N data bytes. The header is excluded from the sum.
- Word k is written to wr_addr = k, for k = 0..N-1.

States: IDLE, LOAD, WRITE, CHECK, DONE, ERR.
- IDLE: in_ready=1; waits for the header.
  - N==0 or N>DEPTH: go to ERR.
  - Otherwise: latch N, clear the byte counter, word index and running sum; go to LOAD.
- LOAD: in_ready=1.
  - Each accepted byte is shifted into the word assembly register and added to the 8-bit running sum; the byte counter increments.
  - The 4th byte of a word goes to WRITE.
- WRITE: in_ready=0; wr_en=1 with wr_addr = word index and wr_data = the assembled word.
  - Then the word index increments.
  - If index+1 == N, go to CHECK; otherwise return to LOAD with the byte counter cleared.
- CHECK: in_ready=1; accepts one byte.
  - Byte equals the running sum: go to DONE.
  - Otherwise: go to ERR.
- DONE: cpu_hold=0, done=1, in_ready=1.
  - A new header byte re-enters the load path exactly as from IDLE: cpu_hold=1 and done=0 from the next cycle.
- ERR: cpu_hold=1, error=1, in_ready=1.
  - A new header byte restarts exactly as from IDLE: error clears on the next cycle.
  - Words already written on a rejected load are not undone; cpu_hold keeps the core from executing them.
- cpu_hold is 1 in every state except DONE.
- The running sum wraps mod 256; the word index never exceeds N-1.

## Timing
Reset values, while rst is high and after its release:
- in_ready=0 while rst is high.
- wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0.
- State IDLE; in_ready=1 in the first cycle after rst falls.

Latencies:
- wr_en, wr_addr and wr_data are registered. The 4th byte of a word accepted at edge t gives wr_en=1 during cycle t+1, for exactly one cycle.
- The header accepted at edge t gives error=1 from t+1 when N is illegal.
- The checksum byte accepted at edge t gives done or error from t+1.

Throughput and handshake:
- Steady-state throughput is 4 bytes per 5 cycles, because in_ready drops for the WRITE cycle.
- A byte held on in_data while in_ready=0 is not consumed and must remain valid until accepted.
- in_valid=0 in any state leaves all state unchanged.

rst asserted mid-load, at any state:
- The next edge returns the block to IDLE with all reset values.
- The partial word is discarded and no further write is issued.

## Test plan
- Good load, N=2: bytes 02, 13 01 50 00, 33 02 21 00, BA.
  - wr_en pulses twice: (addr 0, 0x00500113), then (addr 1, 0x00210233).
  - done=1 and cpu_hold=0 one cycle after BA is accepted.
- Same stream with checksum BB.
  - Both writes still occur.
  - error=1, cpu_hold=1, done=0.
- Header 00, then header 21 (33 > DEPTH 32).
  - Each gives error=1 on the next cycle and no wr_en.
  - Then a good N=1 load (01, 78 56 34 12, 14) ends with done=1 and error=0.
- in_valid held high back-to-back for N=3.
  - in_ready=0 for exactly one cycle after every 4th data byte.
  - No byte is lost or duplicated; exactly 3 writes to addresses 0, 1, 2.
- rst pulsed after header 02 and 5 data bytes.
  - No further wr_en; outputs return to reset values.
  - A subsequent full N=2 load writes from addr 0 and completes with done=1.
- Reload from DONE: header 01 sent while done=1.
  - cpu_hold=1 and done=0 from the next cycle.
  - The load completes and done=1 again.
